// File: rtl/twos_to_signmag_serial_if.sv
// rtl/twos_to_signmag_serial_if.sv - handshake bundle for the serial two's-complement to sign/magnitude converter
//
// Signals:
//   in_valid/in_ready/in         : input word handshake (two's-complement word)
//   out_valid/out_ready          : result handshake
//   sign/mag                     : sign/magnitude result
//   ovf                          : most-negative input flag (only when OVF_FLAG_EN is defined)
// Modports: master = word producer / result consumer, slave = converter.
// Optional feature macro: OVF_FLAG_EN.

interface twos_to_signmag_serial_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in;
  logic             out_valid;
  logic             out_ready;
  logic             sign;
  logic [WIDTH-2:0] mag;
`ifdef OVF_FLAG_EN
  logic             ovf;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, sign, mag, ovf
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, sign, mag, ovf
  );
`else
  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, sign, mag
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, sign, mag
  );
`endif
endinterface

// File: rtl/twos_to_signmag_serial.sv
// rtl/twos_to_signmag_serial.sv - bit-serial two's-complement to sign/magnitude converter
//
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : twos_to_signmag_serial_if.slave (in_valid/in_ready/in, out_valid/out_ready, sign, mag[, ovf])
// Operation: IDLE accepts a word, SHIFT walks it LSB first for WIDTH edges using
// serial negation for negative words, DONE holds the result until out_ready.
// The most-negative input saturates to sign=1, mag=all ones.
// Optional feature macro: OVF_FLAG_EN adds the ovf flag for the most-negative input.

module twos_to_signmag_serial #(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  twos_to_signmag_serial_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-2:0] res;
  logic             seen;
  logic             sign_r;
  logic [WIDTH-2:0] mag_r;
  logic             in_ready_r;
  logic             out_valid_r;
`ifdef OVF_FLAG_EN
  logic             ovf_r;
`endif

  logic obit;
  logic sat;

  always_comb begin
    obit = sreg[0];
    sat  = 1'b0;
    // Serial negation: copy up to and including the first 1, invert afterwards.
    if (sign_r && seen) begin
      obit = ~sreg[0];
    end
    // A negative word whose negation has an all-zero magnitude can only be
    // the most-negative value; that one saturates.
    if (sign_r && (res == '0)) begin
      sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sreg        <= '0;
      res         <= '0;
      seen        <= 1'b0;
      sign_r      <= 1'b0;
      mag_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
`ifdef OVF_FLAG_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sreg       <= bus.in;
            sign_r     <= bus.in[WIDTH-1];
            cnt        <= '0;
            seen       <= 1'b0;
            res        <= '0;
            in_ready_r <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          sreg <= sreg >> 1;
          seen <= seen | sreg[0];
          cnt  <= cnt + 1'b1;
          // Only the low WIDTH-1 result bits form the magnitude; the bit
          // processed on the last edge is the result MSB and is dropped.
          if (cnt != LAST) begin
            res <= (res >> 1) | ((WIDTH-1)'(obit) << (WIDTH - 2));
          end else begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            mag_r       <= sat ? '1 : res;
`ifdef OVF_FLAG_EN
            ovf_r       <= sat;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
`ifdef OVF_FLAG_EN
            ovf_r       <= 1'b0;
`endif
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sign      = sign_r;
  assign bus.mag       = mag_r;
`ifdef OVF_FLAG_EN
  assign bus.ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// tb/tb_twos_to_signmag_serial.sv - randomized self-checking bench for twos_to_signmag_serial

module tb_twos_to_signmag_serial;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  twos_to_signmag_serial_if #(.WIDTH(WIDTH)) bus ();

  twos_to_signmag_serial #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic       exp_sign = 1'b0;
  logic [6:0] exp_mag  = '0;
  logic       exp_ovf  = 1'b0;
  bit         cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: plain signed arithmetic, magnitude clipped to 7 bits.
  function automatic logic [7:0] model(input logic [7:0] w);
    int v;
    int a;
    v = int'($signed(w));
    a = (v < 0) ? -v : v;
    if (a > 127) a = 127;
    return {w[7], 7'(a)};
  endfunction

  // Continuous compare on the falling edge whenever a result is presented.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      if (bus.out_valid === 1'b1) begin
        check("cmp_sign", bus.sign, exp_sign);
        check("cmp_mag", bus.mag, exp_mag);
        check("cmp_in_ready_low", bus.in_ready, 1'b0);
`ifdef OVF_FLAG_EN
        check("cmp_ovf", bus.ovf, exp_ovf);
`endif
      end else begin
`ifdef OVF_FLAG_EN
        check("cmp_ovf_idle", bus.ovf, 1'b0);
`endif
      end
    end
  end

  task automatic send(input logic [7:0] w, input int hold, input bit lit,
                      input logic ls, input logic [6:0] lm);
    int lat;
    logic [7:0] m;
    lat = 0;
    while (bus.in_ready !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("in_ready_before_accept", bus.in_ready, 1'b1);
    m = model(w);
    exp_sign = m[7];
    exp_mag  = m[6:0];
    exp_ovf  = (w == 8'h80);
    cmp_en   = 1'b1;
    bus.in_valid = 1'b1;
    bus.in       = w;
    @(posedge clk); #1;
    check("shift_in_ready", bus.in_ready, 1'b0);
    check("shift_out_valid", bus.out_valid, 1'b0);
    lat = 0;
    do begin
      // Noise on in_valid/in/out_ready must have no effect during SHIFT.
      bus.in_valid  = 1'($urandom);
      bus.in        = 8'($urandom);
      bus.out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end while (bus.out_valid !== 1'b1 && lat < 40);
    check("latency", lat, WIDTH);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'($urandom);
    bus.in        = 8'($urandom);
    if (lit) begin
      check("lit_sign", bus.sign, ls);
      check("lit_mag", bus.mag, lm);
    end
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom);
      bus.in       = 8'($urandom);
      @(posedge clk); #1;
      check("hold_out_valid", bus.out_valid, 1'b1);
      check("hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("handshake_out_valid", bus.out_valid, 1'b0);
    check("handshake_in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b1;
    bus.in        = 8'hFB;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_sign", bus.sign, 1'b0);
    check("rst_mag", bus.mag, 7'd0);
`ifdef OVF_FLAG_EN
    check("rst_ovf", bus.ovf, 1'b0);
`endif
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", bus.in_ready, 1'b1);

    // Directed words with hand-computed results.
    send(8'hFB, 0, 1'b1, 1'b1, 7'd5);
    send(8'h05, 0, 1'b1, 1'b0, 7'd5);
    send(8'h00, 0, 1'b1, 1'b0, 7'd0);
    send(8'h80, 1, 1'b1, 1'b1, 7'h7F);
    send(8'h7F, 0, 1'b1, 1'b0, 7'h7F);
    send(8'h81, 0, 1'b1, 1'b1, 7'h7F);
    send(8'hFB, 5, 1'b1, 1'b1, 7'd5);

    // Reset on the 4th SHIFT edge aborts the word.
    bus.in_valid = 1'b1;
    bus.in       = 8'hFF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("abort_out_valid", bus.out_valid, 1'b0);
      check("abort_in_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;
    end
    send(8'hFF, 0, 1'b1, 1'b1, 7'd1);

    // Randomized words against the model.
    for (int n = 0; n < 40; n++) begin
      send(8'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b0, 7'd0);
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
